// File: rtl/multiport_register_file.sv
// Multiported architectural register file with write bypass and PC alias.
// PC_IDX has no storage; writes to it leave as a registered redirect pulse.
module multiport_register_file #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int PC_IDX     = 15,
  parameter int PC_OFFSET  = 8,
  parameter int RESET_MODE = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0]        pc_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic                     pc_wr_valid_o,
  output logic [DATA_W-1:0]        pc_wr_data_o
);

  localparam int NPHYS = NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [NPHYS];
  logic [DATA_W-1:0] regs_d [NPHYS];

  logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;
  logic                     pc_vld_q, pc_vld_d;
  logic [DATA_W-1:0]        pc_dat_q, pc_dat_d;
  logic [DATA_W-1:0]        pc_rd;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [DATA_W-1:0] rv [NUM_RD];

  // Architectural index to storage slot: indices above PC_IDX shift down.
  function automatic logic [ADDR_W-1:0] phys(input logic [ADDR_W-1:0] a);
    return (a > PC_A) ? a - 1'b1 : a;
  endfunction

  assign pc_rd = pc_i + DATA_W'(PC_OFFSET);

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wa[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
    assign wd[w] = wr_data_i[w*DATA_W +: DATA_W];
  end

  always_comb begin
    regs_d   = regs_q;
    pc_vld_d = 1'b0;
    pc_dat_d = pc_dat_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        if (wa[w] == PC_A) begin
          pc_vld_d = 1'b1;
          pc_dat_d = wd[w];
        end else begin
          regs_d[phys(wa[w])] = wd[w];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    assign ra[r] = rd_addr_i[r*ADDR_W +: ADDR_W];
    always_comb begin
      rv[r] = regs_q[phys(ra[r])];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wa[w] == ra[r]) rv[r] = wd[w];
      end
      if (ra[r] == PC_A) rv[r] = pc_rd;
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (rd_en_i) begin
      for (int r = 0; r < NUM_RD; r++) rd_d[r*DATA_W +: DATA_W] = rv[r];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int p = 0; p < NPHYS; p++) begin
        if (RESET_MODE == 1)
          regs_q[p] <= DATA_W'((p < PC_IDX) ? p : p + 1);
        else
          regs_q[p] <= '0;
      end
      rd_q     <= '0;
      pc_vld_q <= 1'b0;
      pc_dat_q <= '0;
    end else begin
      regs_q   <= regs_d;
      rd_q     <= rd_d;
      pc_vld_q <= pc_vld_d;
      pc_dat_q <= pc_dat_d;
    end
  end

  assign rd_data_o     = rd_q;
  assign pc_wr_valid_o = pc_vld_q;
  assign pc_wr_data_o  = pc_dat_q;

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the CPU's 16-entry ARM-style register file.
- Provides NUM_RD registered read ports and NUM_WR write ports, with write-to-read bypass, read-port stall hold and PC aliasing on the PC index.
- A write to the PC index produces a registered redirect pulse.
- Sits between decode (read addresses) and writeback (ALU result plus load/base-update writes).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 16: number of architectural registers (power of two).
- ADDR_W, 4: register address width; must equal log2(NUM_REGS).
- NUM_RD, 3: number of read ports.
- NUM_WR, 2: number of write ports.
- PC_IDX, 15: register index aliased to the program counter.
- PC_OFFSET, 8: constant added to pc_i when PC_IDX is read.
- RESET_MODE, 1: 0 = all registers reset to zero; 1 = register i resets to value i.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- reset_i, input, 1: synchronous reset, active-low; the block is in reset when reset_i = 0 at a rising edge.
- rd_en_i, input, 1: read-port update enable; 0 = stall.
- rd_addr_i, input, NUM_RD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- wr_en_i, input, NUM_WR: per-port write enables.
- wr_addr_i, input, NUM_WR*ADDR_W: packed write addresses.
- wr_data_i, input, NUM_WR*DATA_W: packed write data.
- pc_i, input, DATA_W: current fetch PC.
- rd_data_o, output, NUM_RD*DATA_W: packed registered read data.
- pc_wr_valid_o, output, 1: one-cycle pulse when PC_IDX was written.
- pc_wr_data_o, output, DATA_W: branch target accompanying pc_wr_valid_o.

Behaviour:
- Storage: NUM_REGS-1 physical registers. PC_IDX has no storage and is never written into the array.
- Reset (reset_i = 0 at a rising edge):
  - RESET_MODE=1: register i <= i. RESET_MODE=0: register i <= 0.
  - rd_data_o <= 0; pc_wr_valid_o <= 0; pc_wr_data_o <= 0.
  - All writes presented in the same cycle are discarded.
  - Reset takes effect mid-operation regardless of rd_en_i or wr_en_i; no asynchronous path exists.
- Write resolution, per edge out of reset:
  - Each enabled port with address != PC_IDX writes its data.
  - If two ports target the same address, the higher-numbered port wins.
- Read, latency 1:
  - If rd_en_i = 1, each read port k latches a value at the edge: read addr A_k sampled in cycle N, data visible in cycle N+1.
  - If rd_en_i = 0, rd_data_o holds its value and the address is ignored.
- Read source priority for port k, evaluated at the edge:
  1. If A_k == PC_IDX: pc_i + PC_OFFSET, modulo 2^DATA_W.
  2. Else, if any enabled write port targets A_k in the same cycle: that write's data (bypass), using the highest-numbered matching port.
  3. Else: the stored register value.
- PC write:
  - If any enabled write port targets PC_IDX, then next cycle pc_wr_valid_o = 1 and pc_wr_data_o = that port's data (highest-numbered port wins).
  - Otherwise pc_wr_valid_o = 0 and pc_wr_data_o holds its last value.
  - A simultaneous read of PC_IDX still returns pc_i + PC_OFFSET, not the written data.
- Bypass and pc_wr_valid_o are independent of rd_en_i. Writes commit during a stall and become visible on the first read after the stall.
- Read addresses >= NUM_REGS cannot occur because ADDR_W = log2(NUM_REGS).
- Widths: all arithmetic is unsigned DATA_W; the PC offset wraps.

Test Plan:
- Reset, default parameters: hold reset_i = 0 for 1 cycle, release, read addresses 0, 1, 14 -> next cycle rd_data_o ports = 0, 1, 14. With RESET_MODE=0 -> 0, 0, 0.
- Bypass: wr_en_i = 01, wr_addr port0 = 3, data 0xDEADBEEF; same cycle read port0 addr 3 -> next cycle port0 = 0xDEADBEEF. Re-read with no write -> 0xDEADBEEF.
- Write collision: both write ports target r5, port0 data 0x11, port1 data 0x22, read r5 the following cycle -> 0x22. The same-cycle bypass read also returns 0x22.
- PC alias and PC write:
  - pc_i = 0x100, read r15 -> 0x108.
  - pc_i = 0xFFFFFFFC -> 0x00000004 (wrap).
  - Port1 writes r15 with 0x2000 -> next cycle pc_wr_valid_o = 1 and pc_wr_data_o = 0x2000 for exactly one cycle; a later read of r15 still tracks pc_i.
- Stall: rd_en_i = 0 for 3 cycles while addresses change and r7 is written with 0x77 -> rd_data_o is unchanged throughout. Raise rd_en_i with addr 7 -> 0x77.
- Reset mid-operation: r2 = 0xAA, then assert reset_i = 0 in the same cycle as a write of 0x55 to r4 -> after release, r2 = 2, r4 = 4, pc_wr_valid_o = 0.
